sync_fifo_core: RTL and testbench

- Synchronous single-clock FIFO. It is the design under test whose pins the FIFO monitor samples on every falling clock edge.
- Stores FIFO_DEPTH words written through a wr_en/data_in port and returns them in order on a rd_en/data_out port.
- Reports per-cycle handshake status (wr_ack, overflow, underflow) and level flags (full, almostfull, empty, almostempty) plus an occupancy count.
- Feeds the monitor, scoreboard and coverage chain directly. Every output must match the golden-model rules below cycle for cycle.

---
 rtl/sync_fifo_core.sv | 87 ++++++++
 tb/tb_sync_fifo_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO of FIFO_DEPTH words with registered status and count-derived level flags.
// Latency: one cycle from accepted rd_en to data_out; wr_ack/overflow/underflow report the prior cycle.
// Backpressure: writes are dropped while full (overflow) and reads are dropped while empty (underflow).
module sync_fifo_core #(
    parameter int FIFO_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOSTFULL_LVL  = FIFO_DEPTH - 1,
    parameter int ALMOSTEMPTY_LVL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FIFO_WIDTH-1:0]       data_in,
    input  logic                        wr_en,
    input  logic                        rd_en,
    output logic [FIFO_WIDTH-1:0]       data_out,
    output logic                        wr_ack,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        full,
    output logic                        almostfull,
    output logic                        empty,
    output logic                        almostempty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(ALMOSTFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(ALMOSTEMPTY_LVL);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Level flags depend only on count so non-power-of-two depths behave identically.
    assign full        = (count == CNT_FULL);
    assign almostfull  = (count == CNT_AFULL);
    assign empty       = (count == '0);
    assign almostempty = (count == CNT_AEMPT);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is left uninitialised across reset; the pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;

            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end

            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core: a queue-based reference predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT pins.
module tb_sync_fifo_core;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;
    logic [3:0]   count;

    sync_fifo_core #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         ack;
        logic         ovf;
        logic         udf;
        logic         full;
        logic         afull;
        logic         empty;
        logic         aempty;
        logic [3:0]   cnt;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] m_dout = '0;
    int           checks = 0;
    int           errors = 0;
    int           cyc_no = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and predict the outputs seen at the following negedge.
    task automatic drive(input logic w, input logic r, input logic rs, input logic [W-1:0] d);
        exp_t e;
        int   sz;
        bit   was_full, was_empty;
        @(negedge clk);
        #1;
        wr_en   = w;
        rd_en   = r;
        rst     = rs;
        data_in = d;
        cyc_no++;
        e = '0;
        if (rs) begin
            model_q.delete();
            m_dout = '0;
        end else begin
            was_full  = (model_q.size() == D);
            was_empty = (model_q.size() == 0);
            if (r && !was_empty) m_dout = model_q.pop_front();
            if (w && !was_full)  model_q.push_back(d);
            e.ack = w && !was_full;
            e.ovf = w && was_full;
            e.udf = r && was_empty;
        end
        sz       = model_q.size();
        e.dout   = m_dout;
        e.cnt    = 4'(sz);
        e.full   = (sz == D);
        e.afull  = (sz == D - 1);
        e.empty  = (sz == 0);
        e.aempty = (sz == 1);
        e.cyc    = cyc_no;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out",    e.cyc, 32'(data_out),    32'(e.dout));
            chk("wr_ack",      e.cyc, 32'(wr_ack),      32'(e.ack));
            chk("overflow",    e.cyc, 32'(overflow),    32'(e.ovf));
            chk("underflow",   e.cyc, 32'(underflow),   32'(e.udf));
            chk("full",        e.cyc, 32'(full),        32'(e.full));
            chk("almostfull",  e.cyc, 32'(almostfull),  32'(e.afull));
            chk("empty",       e.cyc, 32'(empty),       32'(e.empty));
            chk("almostempty", e.cyc, 32'(almostempty), 32'(e.aempty));
            chk("count",       e.cyc, 32'(count),       32'(e.cnt));
        end
    end

    initial begin
        int wp, rp;
        // Reset and idle.
        drive(0, 0, 1, '0);
        drive(0, 0, 0, '0);
        drive(0, 0, 0, '0);
        // Fill to full, then overflow.
        for (int i = 1; i <= D; i++) drive(1, 0, 0, W'(i));
        drive(1, 0, 0, 16'hDEAD);
        // Drain in order, then underflow.
        for (int i = 0; i <= D; i++) drive(0, 1, 0, '0);
        // Simultaneous access while full.
        for (int i = 1; i <= D; i++) drive(1, 0, 0, W'(16'h0010 + i));
        drive(1, 1, 0, 16'h00AA);
        drive(1, 1, 0, 16'h00AB);
        for (int i = 0; i < D; i++) drive(0, 1, 0, '0);
        // Simultaneous access while empty: no fall-through.
        drive(1, 1, 0, 16'h0055);
        drive(0, 1, 0, '0);
        // Reset in mid-operation with a concurrent write.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, W'(16'h0030 + i));
        drive(1, 0, 1, 16'h0077);
        drive(0, 1, 0, '0);
        // Streaming across the pointer wrap.
        for (int i = 0; i < 4; i++) drive(1, 0, 0, W'(16'h0100 + i));
        for (int i = 0; i < 20; i++) drive(1, 1, 0, W'(16'h0200 + i));
        for (int i = 0; i < 5; i++) drive(0, 1, 0, '0);
        // Random traffic in phases biased towards filling, draining and balanced.
        for (int n = 0; n < 3000; n++) begin
            case ((n / 150) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 50; rp = 50; end
            endcase
            drive(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                  ($urandom_range(0, 249) == 0), W'($urandom));
        end
        drive(0, 0, 0, '0);
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
